// File: rtl/swsc_pkg.sv
// Shared types and constants for the swsc frame controller and the swsc core.
package swsc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  localparam int SWSC_KERNEL_H = 7;

  // Bits needed to hold any value 0..max_dim inclusive.
  function automatic int swsc_dim_w(input int max_dim);
    return $clog2(max_dim + 1);
  endfunction

endpackage

// File: rtl/swsc_rc_cnt.sv
// Row/column position counter for a raster pixel stream; flags the last
// pixel of each row (eor) and the last pixel of the frame (eof).
module swsc_rc_cnt #(
  parameter int DIM_W  = 11,
  parameter int HDIM_W = 11
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_step,
  input  logic [DIM_W-1:0]  i_w,
  input  logic [HDIM_W-1:0] i_h,
  output logic              o_eor,
  output logic              o_eof
);

  logic [DIM_W-1:0]  r_col;
  logic [HDIM_W-1:0] r_row;
  logic              w_eor;
  logic              w_eof;

  assign w_eor = (r_col == (i_w - DIM_W'(1)));
  assign w_eof = w_eor && (r_row == (i_h - HDIM_W'(1)));
  assign o_eor = w_eor;
  assign o_eof = w_eof;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_step) begin
      if (w_eor) begin
        r_col <= '0;
        r_row <= w_eof ? '0 : r_row + HDIM_W'(1);
      end else begin
        r_col <= r_col + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/swsc_frame_ctrl.sv
// Frame sequencer in front of the swsc core: marks eor/eof on a plain pixel
// stream and counts core outputs. Optional drain watchdog: SWSC_FRAME_CTRL_TIMEOUT_EN.
module swsc_frame_ctrl
  import swsc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int KERNEL_H    = SWSC_KERNEL_H,
  parameter int MAX_IMG_W   = 1024,
  parameter int MAX_IMG_H   = 1024,
  parameter int TIMEOUT_CYC = 65535,
  parameter int DIM_W       = swsc_dim_w(MAX_IMG_W),
  parameter int HDIM_W      = swsc_dim_w(MAX_IMG_H)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [DIM_W-1:0]         i_img_w,
  input  logic [HDIM_W-1:0]        i_img_h,
  input  logic                     i_s_vld,
  input  logic [DATA_W-1:0]        i_s_data,
  output logic                     o_s_rdy,
  output logic                     o_c_vld,
  output logic                     o_c_eor,
  output logic                     o_c_eof,
  output logic [DATA_W-1:0]        o_c_data,
  input  logic                     i_c_rdy,
  input  logic                     i_r_vld,
  input  logic                     i_r_rdy,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  output logic [DIM_W+HDIM_W-1:0]  o_out_cnt
);

  localparam int CNT_W = DIM_W + HDIM_W;

  ctrl_state_t        r_state;
  logic [DIM_W-1:0]   r_w;
  logic [HDIM_W-1:0]  r_h;
  logic [CNT_W-1:0]   r_exp;
  logic [CNT_W-1:0]   r_out_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               w_run;
  logic               w_cfg_bad;
  logic [CNT_W-1:0]   w_exp_w;
  logic [CNT_W-1:0]   w_exp_h;
  logic [CNT_W-1:0]   w_exp;
  logic               w_clr;
  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_at_exp;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_eor;
  logic               w_eof;

`ifdef SWSC_FRAME_CTRL_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
  logic [WDOG_W-1:0]  r_wdog;
`endif

  assign w_run     = (r_state == RUN);
  assign w_cfg_bad = (i_img_w < DIM_W'(KERNEL_H))  || (i_img_h < HDIM_W'(KERNEL_H)) ||
                     (i_img_w > DIM_W'(MAX_IMG_W)) || (i_img_h > HDIM_W'(MAX_IMG_H));
  assign w_exp_w   = CNT_W'(i_img_w) - CNT_W'(KERNEL_H - 1);
  assign w_exp_h   = CNT_W'(i_img_h) - CNT_W'(KERNEL_H - 1);
  assign w_exp     = w_exp_w * w_exp_h;
  assign w_clr     = (r_state == IDLE) && i_start && !w_cfg_bad;
  assign w_in_hs   = w_run && i_s_vld && i_c_rdy;
  assign w_out_hs  = (w_run || (r_state == DRAIN)) && i_r_vld && i_r_rdy;
  assign w_at_exp  = (r_out_cnt == r_exp);
  assign w_cnt_nxt = (w_out_hs && !w_at_exp) ? r_out_cnt + CNT_W'(1) : r_out_cnt;

  swsc_rc_cnt #(
    .DIM_W  (DIM_W),
    .HDIM_W (HDIM_W)
  ) u_rc_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_step  (w_in_hs),
    .i_w     (r_w),
    .i_h     (r_h),
    .o_eor   (w_eor),
    .o_eof   (w_eof)
  );

  assign o_c_vld   = w_run && i_s_vld;
  assign o_s_rdy   = w_run && i_c_rdy;
  assign o_c_eor   = w_run && w_eor;
  assign o_c_eof   = w_run && w_eof;
  assign o_c_data  = i_s_data;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_out_cnt = r_out_cnt;

  // The output counter saturates at the expected count; any extra core output is an error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_w       <= '0;
      r_h       <= '0;
      r_exp     <= '0;
      r_out_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef SWSC_FRAME_CTRL_TIMEOUT_EN
      r_wdog    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_out_hs) begin
        if (w_at_exp) r_err <= 1'b1;
        else          r_out_cnt <= w_cnt_nxt;
      end
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (w_cfg_bad) begin
              r_err <= 1'b1;
            end else begin
              r_w       <= i_img_w;
              r_h       <= i_img_h;
              r_exp     <= w_exp;
              r_out_cnt <= '0;
              r_err     <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= RUN;
            end
          end
        end
        RUN: begin
          if (w_in_hs && w_eof) begin
            if (w_cnt_nxt == r_exp) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= DRAIN;
            end
`ifdef SWSC_FRAME_CTRL_TIMEOUT_EN
            r_wdog <= '0;
`endif
          end
        end
        DRAIN: begin
          if (w_cnt_nxt == r_exp) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
`ifdef SWSC_FRAME_CTRL_TIMEOUT_EN
          else if (w_out_hs) begin
            r_wdog <= '0;
          end else if (r_wdog == WDOG_W'(TIMEOUT_CYC - 1)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
          end
`endif
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swsc_frame_ctrl.sv
// Directed self-checking bench for swsc_frame_ctrl; a small core model turns
// valid-region pixels into output beats so the output count can be checked.
module tb_swsc_frame_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [10:0] i_img_w;
  logic [10:0] i_img_h;
  logic        i_s_vld;
  logic [7:0]  i_s_data;
  logic        o_s_rdy;
  logic        o_c_vld;
  logic        o_c_eor;
  logic        o_c_eof;
  logic [7:0]  o_c_data;
  logic        i_c_rdy;
  logic        i_r_vld;
  logic        i_r_rdy;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [21:0] o_out_cnt;

  int nChecks = 0;
  int nFail   = 0;

  swsc_frame_ctrl #(
    .DATA_W      (8),
    .KERNEL_H    (7),
    .MAX_IMG_W   (1024),
    .MAX_IMG_H   (1024),
    .TIMEOUT_CYC (100)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_img_w   (i_img_w),
    .i_img_h   (i_img_h),
    .i_s_vld   (i_s_vld),
    .i_s_data  (i_s_data),
    .o_s_rdy   (o_s_rdy),
    .o_c_vld   (o_c_vld),
    .o_c_eor   (o_c_eor),
    .o_c_eof   (o_c_eof),
    .o_c_data  (o_c_data),
    .i_c_rdy   (i_c_rdy),
    .i_r_vld   (i_r_vld),
    .i_r_rdy   (i_r_rdy),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_out_cnt (o_out_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
      else begin
        nFail++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic startFrame(input int w, input int h);
    i_start = 1'b1;
    i_img_w = 11'(w);
    i_img_h = 11'(h);
    tick();
    i_start = 1'b0;
  endtask

  // Runs one frame already started; models the core as one output beat per valid-region pixel.
  task automatic applyStimulus(input int w, input int h, input int stallPct, input int bpPct,
                               input int abortAt, input int glitchAt);
    int n, pend, outCnt, expOut, cyc, eorBad, eofCnt, eofPos, openBad, closedBad, dones;
    bit inHs, outHs, glitched;
    n = 0; pend = 0; outCnt = 0; cyc = 0; eorBad = 0; eofCnt = 0; eofPos = 0;
    openBad = 0; closedBad = 0; dones = 0; glitched = 0;
    expOut = (w - 6) * (h - 6);
    while (dones == 0 && cyc < 3000) begin
      cyc++;
      i_s_data = 8'(cyc);
      i_s_vld  = (n >= w * h) ? 1'b1 : ($urandom_range(99) >= 32'(stallPct));
      i_c_rdy  = ($urandom_range(99) >= 32'(stallPct));
      i_r_vld  = (pend > 0);
      i_r_rdy  = ($urandom_range(99) >= 32'(bpPct));
      i_start  = 1'b0;
      if (glitchAt >= 0 && n == glitchAt && !glitched) begin
        i_start = 1'b1; i_img_w = 11'd8; i_img_h = 11'd9; glitched = 1;
      end
      if (abortAt >= 0 && n == abortAt) begin
        i_s_vld = 1'b1; i_c_rdy = 1'b1; i_rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(o_busy), 0);
        checkOutput("abort_done", 32'(o_done), 0);
        checkOutput("abort_err", 32'(o_err), 0);
        checkOutput("abort_out_cnt", 32'(o_out_cnt), 0);
        checkOutput("abort_c_vld", 32'(o_c_vld), 0);
        checkOutput("abort_s_rdy", 32'(o_s_rdy), 0);
        checkOutput("abort_eor_eof", 32'({o_c_eor, o_c_eof}), 0);
        return;
      end
      #1;
      inHs = (n < w * h) && i_s_vld && i_c_rdy;
      if (n < w * h) begin
        if (o_s_rdy !== i_c_rdy || o_c_vld !== i_s_vld) openBad++;
        if (inHs) begin
          if (o_c_eor !== ((((n + 1) % w) == 0) ? 1'b1 : 1'b0)) eorBad++;
          if (o_c_eof === 1'b1) begin eofCnt++; eofPos = n + 1; end
        end
      end else if (o_s_rdy !== 1'b0 || o_c_vld !== 1'b0) begin
        closedBad++;
      end
      outHs = i_r_vld && i_r_rdy;
      tick();
      if (inHs) begin
        if ((n / w) >= 6 && (n % w) >= 6) pend++;
        n++;
      end
      if (outHs) begin pend--; outCnt++; end
      if (o_done === 1'b1) begin
        dones++;
        checkOutput("done_at_exp", 32'(outCnt), 32'(expOut));
      end
    end
    checkOutput("frame_done_seen", 32'(dones), 1);
    checkOutput("eor_positions", 32'(eorBad), 0);
    checkOutput("eof_count", 32'(eofCnt), 1);
    checkOutput("eof_position", 32'(eofPos), 32'(w * h));
    checkOutput("open_path", 32'(openBad), 0);
    checkOutput("closed_path", 32'(closedBad), 0);
    checkOutput("out_cnt", 32'(o_out_cnt), 32'(expOut));
    checkOutput("err_clear", 32'(o_err), 0);
    checkOutput("busy_in_done", 32'(o_busy), 0);
    i_s_vld = 1'b0;
    i_r_vld = 1'b0;
    tick();
    checkOutput("done_one_cycle", 32'(o_done), 0);
    checkOutput("out_cnt_hold", 32'(o_out_cnt), 32'(expOut));
  endtask

  initial begin
    int vldSeen;
    int doneSeen;
    i_rst_n = 1'b0; i_start = 1'b0; i_img_w = '0; i_img_h = '0;
    i_s_vld = 1'b1; i_s_data = 8'hA5; i_c_rdy = 1'b1; i_r_vld = 1'b0; i_r_rdy = 1'b1;
    repeat (2) tick();
    checkOutput("rst_busy", 32'(o_busy), 0);
    checkOutput("rst_done", 32'(o_done), 0);
    checkOutput("rst_err", 32'(o_err), 0);
    checkOutput("rst_out_cnt", 32'(o_out_cnt), 0);
    checkOutput("rst_c_vld", 32'(o_c_vld), 0);
    checkOutput("rst_s_rdy", 32'(o_s_rdy), 0);
    checkOutput("idle_data_pass", 32'(o_c_data), 32'h0A5);
    i_rst_n = 1'b1;
    tick();

    $display("[TB] 20x20 frame, no stalls");
    startFrame(20, 20);
    checkOutput("start_busy", 32'(o_busy), 1);
    applyStimulus(20, 20, 0, 0, -1, -1);

    $display("[TB] 20x20 frame, stalls and backpressure");
    startFrame(20, 20);
    applyStimulus(20, 20, 5, 10, -1, -1);

    $display("[TB] bad configurations");
    i_s_vld = 1'b1;
    startFrame(6, 20);
    checkOutput("w6_err", 32'(o_err), 1);
    checkOutput("w6_busy", 32'(o_busy), 0);
    vldSeen = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_c_vld !== 1'b0) vldSeen++;
      tick();
    end
    checkOutput("w6_no_c_vld", 32'(vldSeen), 0);
    startFrame(1025, 20);
    checkOutput("w1025_err", 32'(o_err), 1);
    checkOutput("w1025_busy", 32'(o_busy), 0);
    checkOutput("w1025_c_vld", 32'(o_c_vld), 0);
    startFrame(7, 7);
    checkOutput("restart_err_clear", 32'(o_err), 0);
    checkOutput("restart_busy", 32'(o_busy), 1);
    applyStimulus(7, 7, 0, 0, -1, -1);

    $display("[TB] restart pulse during RUN");
    startFrame(20, 20);
    applyStimulus(20, 20, 0, 0, -1, 50);

    $display("[TB] async reset mid-frame");
    startFrame(20, 20);
    applyStimulus(20, 20, 0, 0, 150, -1);
    tick();
    i_rst_n = 1'b1;
    i_s_vld = 1'b0;
    tick();
    checkOutput("post_abort_busy", 32'(o_busy), 0);
    startFrame(20, 20);
    applyStimulus(20, 20, 0, 0, -1, -1);

`ifdef SWSC_FRAME_CTRL_TIMEOUT_EN
    $display("[TB] drain watchdog");
    startFrame(8, 8);
    i_s_vld = 1'b1; i_c_rdy = 1'b1; i_r_vld = 1'b1; i_r_rdy = 1'b0;
    repeat (64) tick();
    checkOutput("wd_drain_busy", 32'(o_busy), 1);
    doneSeen = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (o_done === 1'b1) doneSeen++;
      if (k == 99) begin
        checkOutput("wd_err_before", 32'(o_err), 0);
        checkOutput("wd_busy_before", 32'(o_busy), 1);
      end
    end
    checkOutput("wd_err", 32'(o_err), 1);
    checkOutput("wd_idle", 32'(o_busy), 0);
    checkOutput("wd_no_done", 32'(doneSeen), 0);
    checkOutput("wd_out_cnt", 32'(o_out_cnt), 0);
    i_r_vld = 1'b0;
`else
    doneSeen = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
